// File: rtl/iccm_loader_pkg.sv
// iccm_loader_pkg: shared loader FSM state encoding and frame field width
package iccm_loader_pkg;
    localparam int LOADER_FIELD_BYTES = 4;
    typedef enum logic [2:0] {
        S_BASE,
        S_COUNT,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } loader_state_e;
endpackage

// File: rtl/iccm_loader_byte_word_assembler.sv
// iccm_loader_byte_word_assembler: packs accepted little-endian bytes into 32-bit words
// ports: byte_i/fire_i accepted byte and its handshake; word_o/word_valid_o completed word, valid on the 4th byte
module iccm_loader_byte_word_assembler
    import iccm_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_i,
    input  logic        fire_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);
    logic [1:0]  lane_q;
    logic [23:0] acc_q;
    // earlier bytes shift down so byte k ends in bits [8k+7:8k] when byte 3 arrives
    assign word_o       = {byte_i, acc_q};
    assign word_valid_o = fire_i && lane_q == 2'(LOADER_FIELD_BYTES - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q <= '0;
            acc_q  <= '0;
        end else if (fire_i) begin
            lane_q <= lane_q + 2'd1;
            acc_q  <= {byte_i, acc_q[23:8]};
        end
    end
endmodule

// File: rtl/iccm_loader.sv
// iccm_loader: boot-time ICCM writer for a framed BASE/COUNT/DATA/CSUM byte stream
// ports: in_data/in_valid/in_ready byte stream; iccm_wen/iccm_waddr/iccm_wdata registered ICCM write;
//        core_hold core reset hold; done/error sticky frame outcome
module iccm_loader
    import iccm_loader_pkg::*;
#(
    parameter int INSTR_MEM_DEPTH      = 1024,
    parameter int INSTR_MEM_ADDR_WIDTH = 10,
    parameter int INSTR_MEM_WIDTH      = 32,
    parameter int DEPTH                = INSTR_MEM_DEPTH,
    parameter int ADDR_WIDTH           = INSTR_MEM_ADDR_WIDTH,
    parameter int WIDTH                = INSTR_MEM_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  iccm_wen,
    output logic [ADDR_WIDTH-1:0] iccm_waddr,
    output logic [WIDTH-1:0]      iccm_wdata,
    output logic                  core_hold,
    output logic                  done,
    output logic                  error
);
    loader_state_e         state_q, state_d;
    logic [31:0]           base_q, count_q, idx_q, csum_q;
    logic                  wen_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [WIDTH-1:0]      wdata_q;
    logic [31:0]           word;
    logic                  wv, oob;
    // gated by rst so in_ready stays low until the first cycle out of reset
    assign in_ready   = !rst && state_q != S_DONE && state_q != S_ERR;
    assign done       = state_q == S_DONE;
    assign error      = state_q == S_ERR;
    assign core_hold  = !done;
    assign iccm_wen   = wen_q;
    assign iccm_waddr = waddr_q;
    assign iccm_wdata = wdata_q;
    iccm_loader_byte_word_assembler u_asm (
        .clk          (clk),
        .rst          (rst),
        .byte_i       (in_data),
        .fire_i       (in_valid && in_ready),
        .word_o       (word),
        .word_valid_o (wv)
    );
    // 33-bit bounds check so BASE+COUNT cannot wrap past DEPTH
    assign oob = {1'b0, base_q} >= 33'(DEPTH) || {1'b0, base_q} + {1'b0, word} > 33'(DEPTH);
    always_comb begin
        state_d = state_q;
        if (wv) begin
            case (state_q)
                S_BASE:  state_d = S_COUNT;
                S_COUNT: state_d = oob ? S_ERR : word == 32'd0 ? S_CSUM : S_DATA;
                S_DATA:  state_d = idx_q + 32'd1 == count_q ? S_CSUM : S_DATA;
                S_CSUM:  state_d = word == csum_q ? S_DONE : S_ERR;
                default: state_d = state_q;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_BASE;
            base_q  <= '0;
            count_q <= '0;
            idx_q   <= '0;
            csum_q  <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            wen_q   <= wv && state_q == S_DATA;
            if (wv && state_q == S_BASE) base_q <= word;
            if (wv && state_q == S_COUNT) count_q <= word;
            if (wv && state_q == S_DATA) begin
                waddr_q <= ADDR_WIDTH'(base_q + idx_q);
                wdata_q <= WIDTH'(word);
                csum_q  <= csum_q ^ word;
                idx_q   <= idx_q + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_iccm_loader.sv
// tb_iccm_loader: directed frame table plus hand-written reset/backpressure sequences
module tb_iccm_loader;
    logic        clk = 0, rst = 1, in_valid = 0, in_ready;
    logic [7:0]  in_data = 0;
    logic        iccm_wen, core_hold, done, error;
    logic [5:0]  iccm_waddr;
    logic [31:0] iccm_wdata;
    int          checks = 0, errors = 0;
    bit          gap = 0;
    logic [37:0] wq[$];

    iccm_loader #(.DEPTH(64), .ADDR_WIDTH(6)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .iccm_wen(iccm_wen), .iccm_waddr(iccm_waddr), .iccm_wdata(iccm_wdata),
        .core_hold(core_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (iccm_wen === 1'b1) wq.push_back({iccm_waddr, iccm_wdata});

    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0]       base, n, csum;
        logic [3:0][31:0]  w;
        bit                oob, exp_done;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] base, n, w0, w1, w2, csum, input bit oob, exp_done);
        vec_t v;
        v.base = base; v.n = n; v.csum = csum; v.oob = oob; v.exp_done = exp_done;
        v.w = {32'd0, w2, w1, w0};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        forever begin
            @(negedge clk);
            if (gap && $urandom_range(0, 2) == 0) in_valid = 0;
            else begin
                in_data = b;
                in_valid = 1;
                if (in_ready) break;
            end
            t++;
            if (t > 200) begin
                checks++;
                errors++;
                $display("FAIL byte_timeout act=in_ready_low exp=accept byte %h", b);
                return;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_valid = 0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1;
        in_valid = 0;
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_rst_ready"}, in_ready, 0);
        chk({tag, "_rst_wen"}, iccm_wen, 0);
        chk({tag, "_rst_waddr"}, iccm_waddr, 0);
        chk({tag, "_rst_wdata"}, iccm_wdata, 0);
        chk({tag, "_rst_hold"}, core_hold, 1);
        chk({tag, "_rst_done"}, done, 0);
        chk({tag, "_rst_err"}, error, 0);
        rst = 0;
        #1;
        chk({tag, "_ready_after_rst"}, in_ready, 1);
    endtask

    task automatic run_frame(input vec_t v, input bit reset_first, input string tag);
        if (reset_first) begin
            do_reset(tag);
            wq.delete();
        end
        send_word(v.base);
        send_word(v.n);
        if (v.oob) begin
            chk({tag, "_oob_err"}, error, 1);
            chk({tag, "_oob_ready"}, in_ready, 0);
            chk({tag, "_oob_hold"}, core_hold, 1);
            chk({tag, "_oob_done"}, done, 0);
        end else begin
            for (int i = 0; i < int'(v.n); i++) begin
                send_word(v.w[i]);
                chk($sformatf("%s_w%0d_wen", tag, i), iccm_wen, 1);
                chk($sformatf("%s_w%0d_waddr", tag, i), iccm_waddr, 32'(6'(v.base + i)));
                chk($sformatf("%s_w%0d_wdata", tag, i), iccm_wdata, v.w[i]);
            end
            send_word(v.csum);
            chk({tag, "_done"}, done, v.exp_done);
            chk({tag, "_err"}, error, !v.exp_done);
            chk({tag, "_hold"}, core_hold, !v.exp_done);
            chk({tag, "_ready_end"}, in_ready, 0);
        end
        idle(3);
        chk({tag, "_nwrites"}, wq.size(), v.oob ? 0 : v.n);
        for (int i = 0; i < wq.size() && i < 4; i++)
            chk($sformatf("%s_log%0d", tag, i), 32'(wq[i]), v.w[i]);
    endtask

    vec_t vt[8];

    initial begin
        vt[0] = mk(32'h10, 2, 32'hDEADBEEF, 32'h13, 0, 32'hDEADBEFC, 0, 1);
        vt[1] = mk(0, 0, 0, 0, 0, 0, 0, 1);
        vt[2] = mk(63, 2, 0, 0, 0, 0, 1, 0);
        vt[3] = mk(0, 1, 32'h12345678, 0, 0, 32'h12345679, 0, 0);
        vt[4] = mk(64, 0, 0, 0, 0, 0, 1, 0);
        vt[5] = mk(62, 2, 32'h1, 32'h2, 0, 32'h3, 0, 1);
        vt[6] = mk(0, 32'hFFFFFFFF, 0, 0, 0, 0, 1, 0);
        vt[7] = mk(61, 3, 32'h11111111, 32'h22222222, 32'h44444444, 32'h77777777, 0, 1);

        for (int i = 0; i < 8; i++) run_frame(vt[i], 1, $sformatf("v%0d", i));

        gap = 1;
        run_frame(vt[0], 1, "gap");
        @(negedge clk);
        in_data = 8'hFF;
        in_valid = 1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("post_done_ready%0d", c), in_ready, 0);
            chk($sformatf("post_done_done%0d", c), done, 1);
        end
        idle(2);
        chk("post_done_writes", wq.size(), 2);
        gap = 0;

        do_reset("mid");
        wq.delete();
        send_word(32'h10);
        send_word(32'h2);
        send_byte(8'hEF);
        send_byte(8'hBE);
        @(negedge clk);
        rst = 1;
        in_valid = 0;
        @(posedge clk);
        #1;
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_wen", iccm_wen, 0);
        chk("mid_rst_hold", core_hold, 1);
        @(negedge clk);
        rst = 0;
        run_frame(mk(5, 1, 32'hA5A5A5A5, 0, 0, 32'hA5A5A5A5, 0, 1), 0, "mid");
        if (wq.size() > 0) chk("mid_waddr", 32'(wq[0][37:32]), 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
